jtdd_mcu_com: RTL
=================

Name: jtdd_mcu_com

Overview:
- Shared-RAM bridge and handshake stage between the main 6809 and the sub-MCU.
- Consumes the main CPU's com_cs window, mcu_nmi_set strobe and mcu_halt level.
- Produces mcu_ram read data, mcu_irqmain and mcu_ban back to the main CPU.
- Holds the 512-byte communication RAM and arbitrates single-port access between both processors. Also implements the halt/bus-available handshake and the cross-interrupt latches.

Parameters:
- AW, 9, shared RAM address width (2^AW bytes).
- BAN_DLY, 2, mcu_cen ticks between mcu_halt rising and mcu_ban asserting.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- main_cen  in  1  main CPU clock enable (cpu_cen)
- main_cs  in  1  main CPU selects shared RAM (com_cs)
- main_addr  in  AW  main CPU address
- main_rnw  in  1  main CPU read/not-write
- main_din  in  8  main CPU write data
- main_dout  out  8  shared RAM data to main CPU (mcu_ram)
- nmi_set  in  1  main CPU write strobe requesting MCU NMI
- halt  in  1  main CPU request to halt MCU
- mcu_cen  in  1  MCU clock enable
- mcu_cs  in  1  MCU shared-RAM access
- mcu_addr  in  AW  MCU address
- mcu_we  in  1  MCU write
- mcu_din  in  8  MCU write data
- mcu_dout  out  8  shared RAM data to MCU
- mcu_wait  out  1  stall MCU (lost arbitration or halted)
- mcu_nmi  out  1  level NMI to MCU
- mcu_nmi_ack  in  1  MCU clears its NMI
- mcu_irq_req  in  1  MCU strobe requesting main IRQ
- irqmain  out  1  one-clk pulse to main interrupt flip-flop (mcu_irqmain)
- ban  out  1  MCU bus-available / halted status (mcu_ban)

Behaviour:
- Reset values: main_dout=0, mcu_dout=0, mcu_wait=0, mcu_nmi=0, irqmain=0, ban=0; FSM in IDLE.
- RAM is a single-port jtframe_ram, 2^AW×8, with cen=1. The port is driven by the granted requester only.
- Arbiter FSM states: IDLE, MAIN, MCU.
  - IDLE→MAIN when main_cs.
  - IDLE→MCU when mcu_cs & ~mcu_wait & ~halt.
  - MAIN/MCU→IDLE after one clk.
  - Main always wins a simultaneous request.
- A main request is registered on the first clk with main_cs high. A second grant is not issued until main_cs has dropped or a main_cen edge occurs, so each bus cycle gets exactly one access.
- Read latency is one clk after grant. main_dout/mcu_dout capture RAM q in the cycle after grant and hold until the next read by that side. Writes commit in the grant cycle.
- mcu_wait=1 when:
  - an MCU request is pending while the FSM is in MAIN; or
  - halt=1.
  mcu_wait deasserts in the same clk as the MCU grant.
- Same-address write collision: the main write commits first and the MCU write follows one clk later. The last writer wins, so the MCU value remains.
- NMI latch:
  - Set on rising edge of nmi_set.
  - Cleared on mcu_nmi_ack.
  - Set wins if both occur in the same clk.
- irqmain: rising edge of mcu_irq_req gives exactly one clk high. A held-high request does not retrigger.
- ban handshake:
  - A counter counts mcu_cen ticks while halt=1. ban rises when the count reaches BAN_DLY and stays high while halt=1.
  - halt=0 clears ban and the counter on the next clk.
  - halt dropping before BAN_DLY aborts with ban kept 0.
- Reset mid-access: the FSM returns to IDLE, any pending write is discarded and the latches clear. RAM contents are not cleared.

Decomposition:
- Shared package jtdd_pkg holds:
  - state encoding constants ST_IDLE/ST_MAIN/ST_MCU;
  - COM_AW=9 default;
  - BAN_DLY default.
- One natural sub-module: jtdd_com_arb (FSM, grants, mcu_wait). The RAM reuses jtframe_ram. The handshake latches stay in the top.

Test Plan:
- Main write then read: main writes 0x5A to addr 0x1F0, then reads it → main_dout=0x5A one clk after the read grant. MCU read of 0x1F0 also gives 0x5A.
- Simultaneous access: main_cs and mcu_cs in the same clk, both to addr 0x010 → main granted first. mcu_wait=1 for exactly one clk, then the MCU is granted.
- Write collision: both sides write addr 0x020, main with 0x11 and MCU with 0x22 in the same clk → final content is 0x22.
- NMI handshake: nmi_set pulse → mcu_nmi=1 next clk. mcu_nmi_ack → 0. Set and ack in the same clk → mcu_nmi=1.
- Halt/ban, with mcu_cen every 4 clk:
  - halt=1 → ban=1 after 2 mcu_cen ticks, and mcu_wait=1 throughout.
  - halt=0 → ban=0 next clk.
  - halt held for only 1 tick → ban never asserts.
- IRQ to main: mcu_irq_req held high for 10 clk → irqmain high exactly 1 clk. Reset asserted mid-grant → all outputs return to 0 and RAM data is preserved.

Source files
------------

// File: rtl/jtdd_pkg.sv
// Shared constants for the main-CPU / sub-MCU communication block.
package jtdd_pkg;
   localparam int COM_AW      = 9;
   localparam int COM_BAN_DLY = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAIN = 2'd1,
      ST_MCU  = 2'd2
   } arb_st_e;
endpackage

// File: rtl/jtdd_com_arb.sv
// Shared-RAM arbiter: one-clk grants, main wins ties, each bus cycle gets one access.
module jtdd_com_arb
   import jtdd_pkg::*;
#(
   parameter int AW = COM_AW
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          main_cen,
   input  logic          main_cs,
   input  logic [AW-1:0] main_addr,
   input  logic          main_rnw,
   input  logic [7:0]    main_din,
   input  logic          halt,
   input  logic          mcu_cen,
   input  logic          mcu_cs,
   input  logic [AW-1:0] mcu_addr,
   input  logic          mcu_we,
   input  logic [7:0]    mcu_din,
   output logic [AW-1:0] ram_addr,
   output logic [7:0]    ram_din,
   output logic          ram_we,
   output logic          main_rd,
   output logic          mcu_rd,
   output logic          mcu_wait
);
   arb_st_e st_q, st_d;
   logic    main_done_q, mcu_done_q, wait_q;
   logic    main_req, mcu_req;

   always_comb begin
      main_req = main_cs & ~main_done_q;
      mcu_req  = mcu_cs  & ~mcu_done_q;
      st_d     = ST_IDLE;
      if (st_q == ST_IDLE) begin
         if (main_req)                          st_d = ST_MAIN;
         else if (mcu_req & ~wait_q & ~halt)    st_d = ST_MCU;
      end
   end

   // done flags block a re-grant until the requester starts a new bus cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q        <= ST_IDLE;
         wait_q      <= 1'b0;
         main_done_q <= 1'b0;
         mcu_done_q  <= 1'b0;
      end else begin
         st_q        <= st_d;
         wait_q      <= halt | ((st_d == ST_MAIN) & mcu_req);
         main_done_q <= (st_q == ST_MAIN) | (main_done_q & main_cs & ~main_cen);
         mcu_done_q  <= (st_q == ST_MCU)  | (mcu_done_q  & mcu_cs  & ~mcu_cen);
      end
   end

   always_comb begin
      ram_addr = main_addr;
      ram_din  = main_din;
      if (st_q == ST_MCU) begin
         ram_addr = mcu_addr;
         ram_din  = mcu_din;
      end
      ram_we  = ((st_q == ST_MAIN) & ~main_rnw) | ((st_q == ST_MCU) & mcu_we);
      main_rd = (st_q == ST_MAIN) &  main_rnw;
      mcu_rd  = (st_q == ST_MCU)  & ~mcu_we;
   end

   assign mcu_wait = wait_q;
endmodule

// File: rtl/jtframe_ram.sv
// Generic single-port synchronous RAM, registered read, write-enable gated by cen.
module jtframe_ram #(
   parameter int DW = 8,
   parameter int AW = 10
)(
   input  logic          clk,
   input  logic          cen,
   input  logic [DW-1:0] data,
   input  logic [AW-1:0] addr,
   input  logic          we,
   output logic [DW-1:0] q
);
   logic [DW-1:0] mem [0:(2**AW)-1];

   always_ff @(posedge clk) begin
      if (cen) begin
         q <= mem[addr];
         if (we) mem[addr] <= data;
      end
   end
endmodule

// File: rtl/jtdd_mcu_com.sv
// Main 6809 <-> sub-MCU bridge: shared RAM, halt/bus-available handshake, cross interrupts.
module jtdd_mcu_com
   import jtdd_pkg::*;
#(
   parameter int AW      = COM_AW,
   parameter int BAN_DLY = COM_BAN_DLY
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          main_cen,
   input  logic          main_cs,
   input  logic [AW-1:0] main_addr,
   input  logic          main_rnw,
   input  logic [7:0]    main_din,
   output logic [7:0]    main_dout,
   input  logic          nmi_set,
   input  logic          halt,
   input  logic          mcu_cen,
   input  logic          mcu_cs,
   input  logic [AW-1:0] mcu_addr,
   input  logic          mcu_we,
   input  logic [7:0]    mcu_din,
   output logic [7:0]    mcu_dout,
   output logic          mcu_wait,
   output logic          mcu_nmi,
   input  logic          mcu_nmi_ack,
   input  logic          mcu_irq_req,
   output logic          irqmain,
   output logic          ban
);
   localparam int CW = (BAN_DLY < 1) ? 1 : $clog2(BAN_DLY + 1);

   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_din, ram_q;
   logic          ram_we, main_rd, mcu_rd;

   logic          main_rd_q, mcu_rd_q;
   logic [7:0]    main_hold_q, mcu_hold_q;
   logic          nmi_q, nmi_d, nmi_set_l_q;
   logic          irq_l_q, irqmain_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ban_q;

   jtdd_com_arb #(.AW(AW)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .main_cen  (main_cen),
      .main_cs   (main_cs),
      .main_addr (main_addr),
      .main_rnw  (main_rnw),
      .main_din  (main_din),
      .halt      (halt),
      .mcu_cen   (mcu_cen),
      .mcu_cs    (mcu_cs),
      .mcu_addr  (mcu_addr),
      .mcu_we    (mcu_we),
      .mcu_din   (mcu_din),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_we    (ram_we),
      .main_rd   (main_rd),
      .mcu_rd    (mcu_rd),
      .mcu_wait  (mcu_wait)
   );

   jtframe_ram #(.DW(8), .AW(AW)) u_ram (
      .clk  (clk),
      .cen  (1'b1),
      .data (ram_din),
      .addr (ram_addr),
      .we   (ram_we),
      .q    (ram_q)
   );

   // RAM q is live in the clk after a read grant; the hold register keeps it afterwards
   assign main_dout = main_rd_q ? ram_q : main_hold_q;
   assign mcu_dout  = mcu_rd_q  ? ram_q : mcu_hold_q;

   always_comb begin
      nmi_d = nmi_q;
      if (mcu_nmi_ack)               nmi_d = 1'b0;
      if (nmi_set & ~nmi_set_l_q)    nmi_d = 1'b1;
      cnt_d = cnt_q;
      if (!halt)                                   cnt_d = '0;
      else if (mcu_cen && cnt_q != CW'(BAN_DLY))   cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_rd_q   <= 1'b0;
         mcu_rd_q    <= 1'b0;
         main_hold_q <= 8'd0;
         mcu_hold_q  <= 8'd0;
         nmi_q       <= 1'b0;
         nmi_set_l_q <= 1'b0;
         irq_l_q     <= 1'b0;
         irqmain_q   <= 1'b0;
         cnt_q       <= '0;
         ban_q       <= 1'b0;
      end else begin
         main_rd_q   <= main_rd;
         mcu_rd_q    <= mcu_rd;
         if (main_rd_q) main_hold_q <= ram_q;
         if (mcu_rd_q)  mcu_hold_q  <= ram_q;
         nmi_q       <= nmi_d;
         nmi_set_l_q <= nmi_set;
         irq_l_q     <= mcu_irq_req;
         irqmain_q   <= mcu_irq_req & ~irq_l_q;
         cnt_q       <= cnt_d;
         ban_q       <= halt & (cnt_d == CW'(BAN_DLY));
      end
   end

   assign mcu_nmi = nmi_q;
   assign irqmain = irqmain_q;
   assign ban     = ban_q;
endmodule
